ysyx_22050243_trap_ctrl: RTL and testbench
==========================================

YSYX_22050243_TRAP_CTRL -- requirements
Module: ysyx_22050243_trap_ctrl

Interface
REQ-001 SHALL have parameter IBUS_DATA_WIDTH, default 32, instruction width.
REQ-002 SHALL have parameter DBUS_DATA_WIDTH, default 64, PC/CSR width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wb_valid, input, 1, WB stage holds a retiring instruction.
REQ-006 SHALL have port inst_mem_2_wb_ff, input, IBUS_DATA_WIDTH, WB instruction.
REQ-007 SHALL have port pc_mem_2_wb_ff, input, DBUS_DATA_WIDTH, WB PC; 0 means bubble.
REQ-008 SHALL have port pc_mtvec, input, DBUS_DATA_WIDTH, current mtvec.
REQ-009 SHALL have port pc_mepc, input, DBUS_DATA_WIDTH, current mepc.
REQ-010 SHALL have port mstatus, input, DBUS_DATA_WIDTH, current mstatus; bit 3 = MIE.
REQ-011 SHALL have port mie, input, DBUS_DATA_WIDTH, current mie; bit 7 = MTIE.
REQ-012 SHALL have port timer_irq, input, 1, level-sensitive machine timer request.
REQ-013 SHALL have port mem_busy, input, 1, data-bus transaction outstanding; interrupt entry is blocked while high.
REQ-014 SHALL have port excep_csr_update, output, 2, CSR trap-entry command: 00 none, 01 ecall, 10 timer interrupt.
REQ-015 SHALL have port mret_csr_update, output, 1, CSR mret command.
REQ-016 SHALL have port flush, output, 1, kill all instructions in IF..WB.
REQ-017 SHALL have port redirect_valid, output, 1, fetch-PC override strobe.
REQ-018 SHALL have port redirect_pc, output, DBUS_DATA_WIDTH, override target.
REQ-019 SHALL have port trap_busy, output, 1, stall front end while the controller is not IDLE or is issuing.

Function
REQ-020 SHALL implement FSM states IDLE, IRQ_WAIT, REDIRECT.
REQ-021 SHALL define ecall as wb_valid & inst == 32'h0000_0073 and mret as wb_valid & inst == 32'h3020_0073.
REQ-022 SHALL define irq_pend = timer_irq & mstatus[3] & mie[7].
REQ-023 SHALL use priority irq_pend > ecall > mret when several are present in one cycle.
REQ-024 In IDLE, with irq_pend & !mem_busy, SHALL drive excep_csr_update=10, flush=1, and trap_busy=1 combinationally in the same cycle, then go to REDIRECT.
REQ-025 In IDLE, with irq_pend & mem_busy, SHALL drive no command and go to IRQ_WAIT; ecall/mret in that cycle SHALL be ignored (later re-executed).
REQ-026 In IRQ_WAIT, SHALL hold trap_busy=1; when mem_busy=0 and irq_pend=1, SHALL issue as in REQ-024; if irq_pend drops, SHALL return to IDLE with no command.
REQ-027 In IDLE, with ecall and no irq_pend, SHALL drive excep_csr_update=01 and flush=1 for one cycle, then go to REDIRECT.
REQ-028 In IDLE, with mret and no irq_pend/ecall, SHALL drive mret_csr_update=1 and flush=1 for one cycle, then go to REDIRECT.
REQ-029 SHALL register the trap kind (INT, ECALL, MRET) on entry to REDIRECT.
REQ-030 REDIRECT SHALL last exactly one cycle: redirect_valid=1, flush=1, trap_busy=1, then IDLE.
REQ-031 redirect_pc for ECALL SHALL be {pc_mtvec[63:2],2'b00}.
REQ-032 redirect_pc for INT SHALL be base+28 when pc_mtvec[1:0]==01 (vectored mode), else base, where base={pc_mtvec[63:2],2'b00}.
REQ-033 redirect_pc for MRET SHALL be pc_mepc sampled in the REDIRECT cycle, after the CSR update.
REQ-034 SHALL ignore wb_valid in REDIRECT and IRQ_WAIT; no command SHALL issue there other than per REQ-026.
REQ-035 Command outputs SHALL be one-hot per cycle; excep_csr_update and mret_csr_update SHALL never be nonzero together.
REQ-036 Trap entry to redirect latency SHALL be 1 cycle, and IDLE SHALL be re-entered 2 cycles after issue.
REQ-037 redirect_pc SHALL be 0 whenever redirect_valid=0.

Reset
REQ-038 rst SHALL force IDLE and all outputs to 0 on the next edge, including mid-REDIRECT or IRQ_WAIT; no pending command SHALL survive reset.

Verification
REQ-039 Ecall test: ecall at pc 0x8000_0010, mtvec=0x8000_0100 -> cycle N: excep=01, flush=1; N+1: redirect_valid=1, pc=0x8000_0100; N+2: IDLE.
REQ-040 Mret test: mret, mepc=0x8000_0014 -> N: mret_csr_update=1; N+1: redirect_pc=0x8000_0014.
REQ-041 Interrupt blocked by memory: timer_irq=1, MIE=1, MTIE=1, mem_busy=1 for 3 cycles -> no command, trap_busy=1; first cycle with mem_busy=0: excep=10.
REQ-042 Vectored interrupt with simultaneous ecall: mtvec=0x8000_0201 and both present -> excep=10 only, redirect_pc=0x8000_021C.
REQ-043 Masked interrupt: timer_irq=1 with mstatus[3]=0 -> no command; ecall still handled normally.
REQ-044 Reset in REDIRECT: rst high -> next cycle all outputs 0, state IDLE, and no redirect.

Source files
------------

// File: rtl/ysyx_22050243_trap_ctrl.sv
// Trap controller: sequences timer-interrupt entry, ecall entry and mret
// at the WB stage. It issues a one-cycle CSR command with a pipeline flush,
// then redirects fetch in the following cycle.
module ysyx_22050243_trap_ctrl #(
  parameter int unsigned IBUS_DATA_WIDTH = 32,
  parameter int unsigned DBUS_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [IBUS_DATA_WIDTH-1:0] inst_mem_2_wb_ff,
  input  logic [DBUS_DATA_WIDTH-1:0] pc_mem_2_wb_ff,
  input  logic [DBUS_DATA_WIDTH-1:0] pc_mtvec,
  input  logic [DBUS_DATA_WIDTH-1:0] pc_mepc,
  input  logic [DBUS_DATA_WIDTH-1:0] mstatus,
  input  logic [DBUS_DATA_WIDTH-1:0] mie,
  input  logic                       timer_irq,
  input  logic                       mem_busy,
  output logic [1:0]                 excep_csr_update,
  output logic                       mret_csr_update,
  output logic                       flush,
  output logic                       redirect_valid,
  output logic [DBUS_DATA_WIDTH-1:0] redirect_pc,
  output logic                       trap_busy
);

  localparam logic [IBUS_DATA_WIDTH-1:0] InstEcall = IBUS_DATA_WIDTH'(32'h0000_0073);
  localparam logic [IBUS_DATA_WIDTH-1:0] InstMret  = IBUS_DATA_WIDTH'(32'h3020_0073);

  localparam logic [1:0] CmdNone  = 2'b00;
  localparam logic [1:0] CmdEcall = 2'b01;
  localparam logic [1:0] CmdIrq   = 2'b10;

  typedef enum logic [1:0] {StIdle, StIrqWait, StRedirect} state_e;
  typedef enum logic [1:0] {KindNone, KindInt, KindEcall, KindMret} kind_e;

  state_e state_q, state_d;
  kind_e  kind_q, kind_d;

  logic                       is_ecall;
  logic                       is_mret;
  logic                       irq_pend;
  logic [DBUS_DATA_WIDTH-1:0] mtvec_base;
  logic [DBUS_DATA_WIDTH-1:0] mtvec_vec;

  assign is_ecall   = wb_valid & (inst_mem_2_wb_ff == InstEcall);
  assign is_mret    = wb_valid & (inst_mem_2_wb_ff == InstMret);
  assign irq_pend   = timer_irq & mstatus[3] & mie[7];
  assign mtvec_base = {pc_mtvec[DBUS_DATA_WIDTH-1:2], 2'b00};
  // Machine timer interrupt is cause 7, so its vector sits at base + 4*7.
  assign mtvec_vec  = mtvec_base + DBUS_DATA_WIDTH'(28);

  // The WB PC and the remaining CSR bits do not affect trap sequencing.
  logic unused_inputs;
  assign unused_inputs = ^{pc_mem_2_wb_ff, mstatus, mie};

  // State and trap-kind registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      kind_q  <= KindNone;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  // Next-state decode and command/redirect outputs.
  always_comb begin
    state_d          = state_q;
    kind_d           = kind_q;
    excep_csr_update = CmdNone;
    mret_csr_update  = 1'b0;
    flush            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    trap_busy        = 1'b0;

    // Reset also masks outputs so a pending redirect cannot leak out.
    if (rst) begin
      state_d = StIdle;
      kind_d  = KindNone;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (irq_pend) begin
            if (!mem_busy) begin
              excep_csr_update = CmdIrq;
              flush            = 1'b1;
              trap_busy        = 1'b1;
              kind_d           = KindInt;
              state_d          = StRedirect;
            end else begin
              // ecall/mret in WB are dropped here; the flush on trap entry
              // makes them re-execute after the handler returns.
              state_d = StIrqWait;
            end
          end else if (is_ecall) begin
            excep_csr_update = CmdEcall;
            flush            = 1'b1;
            trap_busy        = 1'b1;
            kind_d           = KindEcall;
            state_d          = StRedirect;
          end else if (is_mret) begin
            mret_csr_update = 1'b1;
            flush           = 1'b1;
            trap_busy       = 1'b1;
            kind_d          = KindMret;
            state_d         = StRedirect;
          end
        end

        StIrqWait: begin
          trap_busy = 1'b1;
          if (!irq_pend) begin
            state_d = StIdle;
          end else if (!mem_busy) begin
            excep_csr_update = CmdIrq;
            flush            = 1'b1;
            kind_d           = KindInt;
            state_d          = StRedirect;
          end
        end

        StRedirect: begin
          redirect_valid = 1'b1;
          flush          = 1'b1;
          trap_busy      = 1'b1;
          unique case (kind_q)
            KindInt:   redirect_pc = (pc_mtvec[1:0] == 2'b01) ? mtvec_vec : mtvec_base;
            KindEcall: redirect_pc = mtvec_base;
            // mepc is read live so the value written by the mret update is used.
            KindMret:  redirect_pc = pc_mepc;
            default:   redirect_pc = '0;
          endcase
          kind_d  = KindNone;
          state_d = StIdle;
        end

        default: begin
          state_d = StIdle;
          kind_d  = KindNone;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_trap_ctrl.sv
// Self-checking bench for the trap controller: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_ysyx_22050243_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [31:0] inst;
  logic [63:0] pc_wb;
  logic [63:0] pc_mtvec;
  logic [63:0] pc_mepc;
  logic [63:0] mstatus;
  logic [63:0] mie;
  logic        timer_irq;
  logic        mem_busy;
  logic [1:0]  excep_csr_update;
  logic        mret_csr_update;
  logic        flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        trap_busy;

  int checks = 0;
  int passed = 0;

  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;

  // {excep, mret, flush, redirect_valid, trap_busy}
  wire [5:0] outs = {excep_csr_update, mret_csr_update, flush, redirect_valid, trap_busy};

  always #5 clk = ~clk;

  ysyx_22050243_trap_ctrl #(
    .IBUS_DATA_WIDTH(32),
    .DBUS_DATA_WIDTH(64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_valid         (wb_valid),
    .inst_mem_2_wb_ff (inst),
    .pc_mem_2_wb_ff   (pc_wb),
    .pc_mtvec         (pc_mtvec),
    .pc_mepc          (pc_mepc),
    .mstatus          (mstatus),
    .mie              (mie),
    .timer_irq        (timer_irq),
    .mem_busy         (mem_busy),
    .excep_csr_update (excep_csr_update),
    .mret_csr_update  (mret_csr_update),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .trap_busy        (trap_busy)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    wb_valid  = 1'b0;
    inst      = 32'h0000_0013;
    pc_wb     = 64'h0;
    pc_mtvec  = 64'h0;
    pc_mepc   = 64'h0;
    mstatus   = 64'h0;
    mie       = 64'h0;
    timer_irq = 1'b0;
    mem_busy  = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst      = 1'b1;
    wb_valid = 1'b1;
    inst     = ECALL;
    next();
    @(negedge clk);
    checks++;
    if (outs !== 6'b0 || redirect_pc !== 64'h0)
      $display("FAIL reset_hold outs=%b pc=%h required outs=000000 pc=0", outs, redirect_pc);
    else passed++;
    set_idle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 6'b0 || redirect_pc !== 64'h0)
      $display("FAIL reset_idle outs=%b pc=%h required outs=000000 pc=0", outs, redirect_pc);
    else passed++;
    next();
  endtask

  task automatic test_ecall();
    do_reset();
    pc_mtvec = 64'h8000_0100;
    pc_wb    = 64'h8000_0010;
    wb_valid = 1'b1;
    inst     = ECALL;
    @(negedge clk);
    checks++;
    if (outs !== {2'b01, 1'b0, 1'b1, 1'b0, 1'b1})
      $display("FAIL ecall_issue outs=%b required 010101", outs);
    else passed++;
    next();
    // ecall still visible in WB during REDIRECT must be ignored
    @(negedge clk);
    checks++;
    if (outs !== {2'b00, 1'b0, 1'b1, 1'b1, 1'b1} || redirect_pc !== 64'h8000_0100)
      $display("FAIL ecall_redirect outs=%b pc=%h required 000111 pc=80000100", outs, redirect_pc);
    else passed++;
    next();
    wb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 6'b0 || redirect_pc !== 64'h0)
      $display("FAIL ecall_back_idle outs=%b pc=%h required 000000 pc=0", outs, redirect_pc);
    else passed++;
    next();
  endtask

  task automatic test_mret();
    do_reset();
    pc_mepc  = 64'h0000_1234;
    wb_valid = 1'b1;
    inst     = MRET;
    @(negedge clk);
    checks++;
    if (outs !== {2'b00, 1'b1, 1'b1, 1'b0, 1'b1})
      $display("FAIL mret_issue outs=%b required 001101", outs);
    else passed++;
    next();
    // CSR update lands: mepc changes, redirect must follow the new value
    wb_valid = 1'b0;
    pc_mepc  = 64'h8000_0014;
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0014 || mret_csr_update !== 1'b0)
      $display("FAIL mret_redirect rv=%b pc=%h mret=%b required rv=1 pc=80000014 mret=0",
               redirect_valid, redirect_pc, mret_csr_update);
    else passed++;
    next();
  endtask

  task automatic test_irq_blocked();
    do_reset();
    pc_mtvec  = 64'h8000_0100;
    mstatus   = 64'h8;
    mie       = 64'h80;
    timer_irq = 1'b1;
    mem_busy  = 1'b1;
    wb_valid  = 1'b1;
    inst      = ECALL;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (excep_csr_update !== 2'b00 || mret_csr_update !== 1'b0 || flush !== 1'b0 ||
          (i > 0 && trap_busy !== 1'b1))
        $display("FAIL irq_blocked_%0d exc=%b mret=%b flush=%b busy=%b required no command, busy",
                 i, excep_csr_update, mret_csr_update, flush, trap_busy);
      else passed++;
      next();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== {2'b10, 1'b0, 1'b1, 1'b0, 1'b1})
      $display("FAIL irq_release outs=%b required 100101", outs);
    else passed++;
    next();
    timer_irq = 1'b0;
    wb_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0100)
      $display("FAIL irq_redirect rv=%b pc=%h required rv=1 pc=80000100", redirect_valid, redirect_pc);
    else passed++;
    next();
    // pending interrupt that goes away while waiting: back to idle, no command
    timer_irq = 1'b1;
    mem_busy  = 1'b1;
    next();
    timer_irq = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== {2'b00, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL irq_drop outs=%b required 000001", outs);
    else passed++;
    next();
    @(negedge clk);
    checks++;
    if (outs !== 6'b0)
      $display("FAIL irq_drop_idle outs=%b required 000000", outs);
    else passed++;
    mem_busy = 1'b0;
    next();
  endtask

  task automatic test_vectored();
    do_reset();
    pc_mtvec  = 64'h8000_0201;
    mstatus   = 64'h8;
    mie       = 64'h80;
    timer_irq = 1'b1;
    wb_valid  = 1'b1;
    inst      = ECALL;
    @(negedge clk);
    checks++;
    if (outs !== {2'b10, 1'b0, 1'b1, 1'b0, 1'b1})
      $display("FAIL vectored_issue outs=%b required 100101", outs);
    else passed++;
    next();
    timer_irq = 1'b0;
    wb_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_021C)
      $display("FAIL vectored_pc rv=%b pc=%h required rv=1 pc=8000021c", redirect_valid, redirect_pc);
    else passed++;
    next();
  endtask

  task automatic test_masked();
    do_reset();
    pc_mtvec  = 64'h8000_0300;
    mstatus   = 64'h0;
    mie       = 64'h80;
    timer_irq = 1'b1;
    wb_valid  = 1'b1;
    inst      = ECALL;
    @(negedge clk);
    checks++;
    if (excep_csr_update !== 2'b01 || flush !== 1'b1)
      $display("FAIL masked_ecall exc=%b flush=%b required exc=01 flush=1", excep_csr_update, flush);
    else passed++;
    next();
    wb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (redirect_pc !== 64'h8000_0300 || excep_csr_update !== 2'b00)
      $display("FAIL masked_redirect pc=%h exc=%b required pc=80000300 exc=00",
               redirect_pc, excep_csr_update);
    else passed++;
    timer_irq = 1'b0;
    next();
  endtask

  task automatic test_reset_redirect();
    do_reset();
    pc_mtvec = 64'h8000_0100;
    wb_valid = 1'b1;
    inst     = ECALL;
    next();
    wb_valid = 1'b0;
    rst      = 1'b1;
    next();
    @(negedge clk);
    checks++;
    if (outs !== 6'b0 || redirect_pc !== 64'h0)
      $display("FAIL reset_in_redirect outs=%b pc=%h required 000000 pc=0", outs, redirect_pc);
    else passed++;
    rst = 1'b0;
    next();
    @(negedge clk);
    checks++;
    if (outs !== 6'b0 || redirect_pc !== 64'h0)
      $display("FAIL reset_no_redirect outs=%b pc=%h required 000000 pc=0", outs, redirect_pc);
    else passed++;
    next();
  endtask

  // Randomized run. The model tracks only "a redirect is owed next cycle
  // (and for which trap)" and "an interrupt is waiting on memory".
  task automatic test_random();
    bit          owe_redirect = 0;
    int          owed_kind = 0;     // 1 interrupt, 2 ecall, 3 mret
    bit          waiting = 0;
    bit          irq, ec, mr;
    logic [63:0] base, e_pc;
    logic [5:0]  e_outs;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      wb_valid = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       inst = ECALL;
        1:       inst = MRET;
        default: inst = $urandom;
      endcase
      pc_wb     = {$urandom, $urandom};
      pc_mtvec  = {$urandom, $urandom};
      pc_mepc   = {$urandom, $urandom};
      mstatus   = {$urandom, $urandom};
      mie       = {$urandom, $urandom};
      timer_irq = $urandom_range(0, 1) == 1;
      mem_busy  = $urandom_range(0, 2) == 0;
      @(negedge clk);

      irq    = timer_irq && mstatus[3] && mie[7];
      ec     = wb_valid && inst == ECALL;
      mr     = wb_valid && inst == MRET;
      base   = pc_mtvec & ~64'h3;
      e_outs = 6'b0;
      e_pc   = 64'h0;
      if (rst) begin
        owe_redirect = 0;
        waiting      = 0;
      end else if (owe_redirect) begin
        e_outs = 6'b00_0111;
        if (owed_kind == 1)      e_pc = (pc_mtvec[1:0] == 2'b01) ? base + 64'd28 : base;
        else if (owed_kind == 2) e_pc = base;
        else                     e_pc = pc_mepc;
        owe_redirect = 0;
      end else if (irq && !mem_busy) begin
        e_outs       = 6'b10_0101;
        owe_redirect = 1;
        owed_kind    = 1;
        waiting      = 0;
      end else if (irq) begin
        e_outs  = waiting ? 6'b00_0001 : 6'b0;
        waiting = 1;
      end else if (waiting) begin
        e_outs  = 6'b00_0001;
        waiting = 0;
      end else if (ec) begin
        e_outs       = 6'b01_0101;
        owe_redirect = 1;
        owed_kind    = 2;
      end else if (mr) begin
        e_outs       = 6'b00_1101;
        owe_redirect = 1;
        owed_kind    = 3;
      end

      checks++;
      if (outs !== e_outs || redirect_pc !== e_pc)
        $display("FAIL random_%0d outs=%b pc=%h required outs=%b pc=%h",
                 i, outs, redirect_pc, e_outs, e_pc);
      else passed++;
      next();
    end
    rst = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_ecall();
    test_mret();
    test_irq_blocked();
    test_vectored();
    test_masked();
    test_reset_redirect();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
